// File: rtl/dtree_if_pkg.sv
// Shared types and constants for the decision-tree feature loader.
package dtree_if_pkg;

  // Loader phases: collect bytes, let the tree settle, present the result.
  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam int DEF_NUM_FEATURES = 7;
  localparam int DEF_FEAT_W       = 8;
  localparam int DEF_CLASS_W      = 5;

  // Position of each named tree input on the feature bus (byte k -> feature k).
  localparam int FI_X6   = 0;
  localparam int FI_X13  = 1;
  localparam int FI_X169 = 2;
  localparam int FI_X236 = 3;
  localparam int FI_X251 = 4;
  localparam int FI_X260 = 5;
  localparam int FI_X278 = 6;

  // Width of a counter that indexes n features (at least one bit).
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dtree_feature_loader.sv
// Byte-stream front end and result back end for the external combinational
// decision-tree core. Bytes fill a parallel feature bus; after a fixed settle
// time the tree's class is captured and offered on a result handshake.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The producer holds valid and its data stable until that edge; ready may be
// low at any time and does not depend combinationally on valid.
module dtree_feature_loader
  import dtree_if_pkg::*;
#(
  parameter int NUM_FEATURES  = DEF_NUM_FEATURES,
  parameter int FEAT_W        = DEF_FEAT_W,
  parameter int CLASS_W       = DEF_CLASS_W,
  parameter int SETTLE_CYCLES = 1,
  localparam int IDX_W        = idx_w(NUM_FEATURES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [FEAT_W-1:0]              s_data,
  input  logic                           s_last,
  output logic [NUM_FEATURES*FEAT_W-1:0] feat_bus,
  input  logic [CLASS_W-1:0]             tree_class,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [CLASS_W-1:0]             m_class,
  output logic                           err_len,
  output state_t                         dbg_state,
  output logic [IDX_W-1:0]               dbg_idx
);

  localparam int                CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_FEATURES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t                          state_q;
  logic [IDX_W-1:0]                idx_q;
  logic [CNT_W-1:0]                cnt_q;
  logic [NUM_FEATURES*FEAT_W-1:0]  feat_q;
  logic [CLASS_W-1:0]              m_class_q;
  logic                            m_valid_q;
  logic                            err_q;
  logic                            s_accept_d;

  // Input is only open while collecting a frame; a byte moves on valid && ready.
  assign s_ready    = (state_q == LOAD);
  assign s_accept_d = s_valid && s_ready;

  assign feat_bus  = feat_q;
  assign m_valid   = m_valid_q;
  assign m_class   = m_class_q;
  assign err_len   = err_q;
  assign dbg_state = state_q;
  assign dbg_idx   = idx_q;

  // Frame sequencer: fills features, times the settle window, holds the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      cnt_q     <= '0;
      feat_q    <= '0;
      m_class_q <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (s_accept_d) begin
            feat_q[idx_q*FEAT_W +: FEAT_W] <= s_data;
            if (idx_q == IDX_LAST) begin
              // Full frame: classify even if the end mark was missing.
              idx_q   <= '0;
              cnt_q   <= '0;
              state_q <= SETTLE;
              err_q   <= !s_last;
            end else if (s_last) begin
              // Short frame: flag it and restart, written bytes stay visible.
              idx_q <= '0;
              err_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            m_class_q <= tree_class;
            m_valid_q <= 1'b1;
            state_q   <= RESULT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESULT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Directed plus randomized bench for dtree_feature_loader with a stand-in
// tree core (class = low bits of feature 6).
module tb_dtree_feature_loader;
  import dtree_if_pkg::*;

  localparam int NF = 7;
  localparam int FW = 8;
  localparam int CW = 5;
  localparam int SC = 1;
  localparam int IW = idx_w(NF);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [FW-1:0]      s_data  = '0;
  logic               s_last  = 1'b0;
  logic [NF*FW-1:0]   feat_bus;
  logic [CW-1:0]      tree_class;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic [CW-1:0]      m_class;
  logic               err_len;
  state_t             dbg_state;
  logic [IW-1:0]      dbg_idx;

  dtree_feature_loader #(
    .NUM_FEATURES(NF), .FEAT_W(FW), .CLASS_W(CW), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .feat_bus(feat_bus), .tree_class(tree_class),
    .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
    .err_len(err_len), .dbg_state(dbg_state), .dbg_idx(dbg_idx)
  );

  // Stand-in tree core.
  assign tree_class = feat_bus[FI_X278*FW +: CW];

  // ---------------- reference model / scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [FW-1:0] model_feat [NF];
  int            model_idx;
  logic [CW-1:0] exp_q[$];

  function automatic logic [NF*FW-1:0] model_bus();
    logic [NF*FW-1:0] b;
    b = '0;
    for (int i = 0; i < NF; i++) b[i*FW +: FW] = model_feat[i];
    return b;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NF; i++) model_feat[i] = '0;
    model_idx = 0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("rst_feat_bus", feat_bus, '0);
    check("rst_m_valid",  m_valid,  0);
    check("rst_m_class",  m_class,  0);
    check("rst_err_len",  err_len,  0);
    check("rst_s_ready",  s_ready,  1);
    check("rst_idx",      dbg_idx,  0);
    check("rst_state",    dbg_state, LOAD);
  endtask

  // Offer one byte after `gap` idle cycles; reports whether it closed a frame.
  task automatic push_byte(input logic [FW-1:0] d, input logic l, input int gap,
                           output bit done);
    bit exp_err;
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1; s_data = d; s_last = l;
    n = 0;
    while (!s_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("s_ready_wait", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_data = FW'($urandom);
    model_feat[model_idx] = d;
    done = 0; exp_err = 0;
    if (model_idx == NF - 1) begin
      done = 1; exp_err = !l; model_idx = 0;
      exp_q.push_back(model_feat[FI_X278][CW-1:0]);
    end else if (l) begin
      exp_err = 1; model_idx = 0;
    end else begin
      model_idx++;
    end
    check("feat_bus", feat_bus, model_bus());
    check("err_len",  err_len,  exp_err);
    check("idx",      dbg_idx,  model_idx);
    if (done) begin
      check("s_ready_settle", s_ready, 0);
      check("m_valid_early",  m_valid, 0);
    end
  endtask

  // Drive a whole frame from the staging array.
  logic [FW-1:0] stage [NF];
  task automatic push_frame(input int len, input bit last_on_end, input bit gaps,
                            output bit done);
    for (int k = 0; k < len; k++)
      push_byte(stage[k], (k == len - 1) ? last_on_end : 1'b0,
                gaps ? int'($urandom_range(0, 1)) : 0, done);
  endtask

  // Expect the result SC cycles after the last byte, hold it, then take it.
  task automatic collect_result(input int hold);
    logic [CW-1:0] exp;
    repeat (SC) @(posedge clk);
    #1;
    check("m_valid_rise", m_valid, 1);
    check("err_len_clear", err_len, 0);
    check("exp_q_has_entry", exp_q.size() > 0, 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("m_class", m_class, exp);
    m_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("bp_m_valid", m_valid, 1);
      check("bp_m_class", m_class, exp);
      check("bp_s_ready", s_ready, 0);
      check("bp_feat_bus", feat_bus, model_bus());
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("hs_m_valid", m_valid, 0);
    check("hs_s_ready", s_ready, 1);
    check("hs_state",   dbg_state, LOAD);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit done;
    logic [CW-1:0] cls_a;
    logic [NF*FW-1:0] bus_a;
    int len;
    bit lst;

    model_reset();
    do_reset();

    // Normal frame 01..07
    for (int k = 0; k < NF; k++) stage[k] = FW'(k + 1);
    push_frame(NF, 1'b1, 1'b0, done);
    check("normal_done", done, 1);
    check("normal_bus", feat_bus, 56'h07060504030201);
    collect_result(0);
    check("normal_class_const", m_class, 5'h07);

    // Early end on byte 3: error pulse, no result
    for (int k = 0; k < 3; k++) stage[k] = FW'(8'hA1 + k);
    push_frame(3, 1'b1, 1'b0, done);
    check("early_done", done, 0);
    @(posedge clk); #1;
    check("early_err_one_pulse", err_len, 0);
    check("early_no_m_valid", m_valid, 0);
    check("early_s_ready", s_ready, 1);
    for (int k = 0; k < NF; k++) stage[k] = FW'(8'h10 + k);
    push_frame(NF, 1'b1, 1'b0, done);
    collect_result(0);
    check("after_early_class", m_class, 5'h16);

    // Missing end mark on byte 7 = FF
    for (int k = 0; k < NF; k++) stage[k] = FW'(8'h20 + k);
    stage[NF-1] = 8'hFF;
    push_frame(NF, 1'b0, 1'b0, done);
    collect_result(0);
    check("nolast_class", m_class, 5'h1F);

    // Backpressure for 10 cycles
    for (int k = 0; k < NF; k++) stage[k] = FW'($urandom);
    push_frame(NF, 1'b1, 1'b0, done);
    collect_result(10);

    // Same frame gapless vs with random gaps
    for (int k = 0; k < NF; k++) stage[k] = FW'($urandom);
    push_frame(NF, 1'b1, 1'b0, done);
    bus_a = feat_bus;
    collect_result(0);
    cls_a = m_class;
    push_frame(NF, 1'b1, 1'b1, done);
    check("gap_bus_same", feat_bus, bus_a);
    collect_result(0);
    check("gap_class_same", m_class, cls_a);

    // Reset during SETTLE
    for (int k = 0; k < NF; k++) stage[k] = FW'($urandom);
    push_frame(NF, 1'b1, 1'b0, done);
    check("settle_state", dbg_state, SETTLE);
    do_reset();
    @(posedge clk); #1;
    check("settle_rst_no_result", m_valid, 0);

    // Reset during RESULT
    push_frame(NF, 1'b1, 1'b0, done);
    @(posedge clk); #1;
    check("result_state", dbg_state, RESULT);
    do_reset();

    // Reset mid-frame, then a fresh frame
    push_frame(4, 1'b0, 1'b0, done);
    do_reset();
    for (int k = 0; k < NF; k++) stage[k] = FW'($urandom);
    push_frame(NF, 1'b1, 1'b0, done);
    collect_result(2);

    // Random frames: random lengths, end marks, gaps and backpressure
    for (int f = 0; f < 40; f++) begin
      len = int'($urandom_range(1, NF));
      lst = (len < NF) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int k = 0; k < NF; k++) stage[k] = FW'($urandom);
      push_frame(len, lst, 1'b1, done);
      if (done) collect_result(int'($urandom_range(0, 4)));
      else begin
        @(posedge clk); #1;
        check("rand_short_no_result", m_valid, 0);
        check("rand_short_err_clear", err_len, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    miscompares++;
    $display("FAIL timeout: observed running expected finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
